// File: rtl/exp5_unidade_controle_jogada_pkg.sv
// Shared definitions for the play-control unit: state codes (also the debug codes),
// default inactivity window and the state-to-output decode.
package exp5_unidade_controle_jogada_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'b0000,
    PREPARACAO  = 4'b0001,
    ESPERA      = 4'b0010,
    REGISTRA    = 4'b0100,
    COMPARACAO  = 4'b0101,
    PROXIMO     = 4'b0110,
    FIM_ACERTO  = 4'b1010,
    FIM_ERRO    = 4'b1110,
    FIM_TIMEOUT = 4'b1101
  } estado_t;

  localparam int         TIMEOUT_PADRAO = 5000;
  localparam logic [3:0] DB_ILEGAL      = 4'b1111;

  typedef struct packed {
    logic       zera_c;
    logic       conta_c;
    logic       zera_r;
    logic       registra_r;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic       timeout_ativo;
    logic [3:0] db_estado;
  } saidas_t;

  // Moore decode; an unknown code reports DB_ILEGAL with every control low.
  function automatic saidas_t decodifica(input estado_t e);
    saidas_t s;
    s           = '0;
    s.db_estado = e;
    case (e)
      INICIAL, PREPARACAO: begin
        s.zera_c = 1'b1;
        s.zera_r = 1'b1;
      end
      ESPERA:      s.timeout_ativo = 1'b1;
      REGISTRA:    s.registra_r    = 1'b1;
      COMPARACAO:  s.db_estado     = e;
      PROXIMO:     s.conta_c       = 1'b1;
      FIM_ACERTO: begin
        s.pronto  = 1'b1;
        s.acertou = 1'b1;
      end
      FIM_ERRO: begin
        s.pronto = 1'b1;
        s.errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        s.pronto  = 1'b1;
        s.timeout = 1'b1;
      end
      default:     s.db_estado = DB_ILEGAL;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/exp5_unidade_controle_jogada_edge_detector.sv
// Rising-edge detector for a synchronous button level; one-cycle pulse per 0->1 change.
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic pulso
);

  logic sinal_ant;

  // history of the input level from the previous cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinal_ant <= 1'b0;
    end else begin
      sinal_ant <= sinal;
    end
  end

  assign pulso = sinal & ~sinal_ant;

endmodule

// File: rtl/exp5_unidade_controle_jogada.sv
// Moore control unit for the memory game: waits for each play press, compares,
// advances the address, and ends in acerto, erro or inactivity timeout.
module exp5_unidade_controle_jogada
  import exp5_unidade_controle_jogada_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       fimC,
  input  logic       igual,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado,
  output logic       db_timeout_ativo
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  estado_t       estado;
  estado_t       prox_estado;
  saidas_t       saidas;
  logic [CW-1:0] tcount;
  logic          jogada_borda;
  logic          fim_janela;

  edge_detector u_borda_jogada (
    .clock (clock),
    .reset (reset),
    .sinal (jogada),
    .pulso (jogada_borda)
  );

  assign fim_janela = (tcount == CW'(TIMEOUT - 1));

  function automatic estado_t calc_proximo(input estado_t e, input logic ini,
                                           input logic borda, input logic janela,
                                           input logic ig, input logic fim);
    estado_t n;
    case (e)
      INICIAL:     n = ini ? PREPARACAO : INICIAL;
      PREPARACAO:  n = ESPERA;
      // a press on the last window cycle still counts: the edge takes priority
      ESPERA:      n = borda ? REGISTRA : (janela ? FIM_TIMEOUT : ESPERA);
      REGISTRA:    n = COMPARACAO;
      COMPARACAO:  n = !ig ? FIM_ERRO : (fim ? FIM_ACERTO : PROXIMO);
      PROXIMO:     n = ESPERA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: n = ini ? PREPARACAO : e;
      default:     n = INICIAL;
    endcase
    return n;
  endfunction

  assign prox_estado = calc_proximo(estado, iniciar, jogada_borda, fim_janela, igual, fimC);

  // state, per-position inactivity counter and outputs decoded from the next state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
      tcount <= '0;
      saidas <= decodifica(INICIAL);
    end else begin
      estado <= prox_estado;
      saidas <= decodifica(prox_estado);
      if (prox_estado == ESPERA && estado == ESPERA) begin
        tcount <= tcount + CW'(1);
      end else begin
        tcount <= '0;
      end
    end
  end

  assign zeraC            = saidas.zera_c;
  assign contaC           = saidas.conta_c;
  assign zeraR            = saidas.zera_r;
  assign registraR        = saidas.registra_r;
  assign pronto           = saidas.pronto;
  assign acertou          = saidas.acertou;
  assign errou            = saidas.errou;
  assign timeout          = saidas.timeout;
  assign db_estado        = saidas.db_estado;
  assign db_timeout_ativo = saidas.timeout_ativo;

endmodule

// File: tb/tb_exp5_unidade_controle_jogada.sv
// Bench: directed game scenarios plus randomized play against a behavioural game model.
module tb_exp5_unidade_controle_jogada;

  localparam int TO = 10;

  // game phases of the reference model
  localparam int PH_IDLE = 0, PH_PREP = 1, PH_WAIT = 2, PH_REG = 3, PH_CMP = 4,
                 PH_NEXT = 5, PH_OK = 6, PH_ERR = 7, PH_TO = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0, jogada = 1'b0, fimC = 1'b0, igual = 1'b0;
  logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;
  logic       db_timeout_ativo;

  int total = 0;
  int bad = 0;
  int m_ph = PH_IDLE;
  int m_waited = 0;
  logic m_jprev = 1'b0;
  int cnt_reg = 0, cnt_conta = 0, cnt_ativo = 0;

  exp5_unidade_controle_jogada #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .fimC(fimC), .igual(igual), .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR),
    .registraR(registraR), .pronto(pronto), .acertou(acertou), .errou(errou),
    .timeout(timeout), .db_estado(db_estado), .db_timeout_ativo(db_timeout_ativo)
  );

  always #5 clock = ~clock;

  wire [12:0] dut_vec = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou,
                         timeout, db_timeout_ativo, db_estado};

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // order: zeraC contaC zeraR registraR pronto acertou errou timeout ativo | db_estado
  function automatic logic [12:0] exp_out(input int ph);
    case (ph)
      PH_IDLE: return {9'b101000000, 4'b0000};
      PH_PREP: return {9'b101000000, 4'b0001};
      PH_WAIT: return {9'b000000001, 4'b0010};
      PH_REG:  return {9'b000100000, 4'b0100};
      PH_CMP:  return {9'b000000000, 4'b0101};
      PH_NEXT: return {9'b010000000, 4'b0110};
      PH_OK:   return {9'b000011000, 4'b1010};
      PH_ERR:  return {9'b000010100, 4'b1110};
      PH_TO:   return {9'b000010010, 4'b1101};
      default: return 13'h1fff;
    endcase
  endfunction

  task automatic model_step();
    logic press;
    press = jogada && !m_jprev;
    m_jprev = jogada;
    case (m_ph)
      PH_IDLE: if (iniciar) m_ph = PH_PREP;
      PH_PREP: begin m_ph = PH_WAIT; m_waited = 0; end
      PH_WAIT: begin
        m_waited++;
        if (press) m_ph = PH_REG;
        else if (m_waited >= TO) m_ph = PH_TO;
      end
      PH_REG:  m_ph = PH_CMP;
      PH_CMP:  m_ph = !igual ? PH_ERR : (fimC ? PH_OK : PH_NEXT);
      PH_NEXT: begin m_ph = PH_WAIT; m_waited = 0; end
      default: if (iniciar) m_ph = PH_PREP;
    endcase
  endtask

  task automatic cycle(input logic ini, input logic jog, input logic ig, input logic fc);
    iniciar = ini; jogada = jog; igual = ig; fimC = fc;
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_eq("outputs", {3'b000, dut_vec}, {3'b000, exp_out(m_ph)});
    if (registraR) cnt_reg++;
    if (contaC) cnt_conta++;
    if (db_timeout_ativo) cnt_ativo++;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1 check_eq("async_reset", {3'b000, dut_vec}, {3'b000, 9'b101000000, 4'b0000});
    #1 reset = 1'b1;
    m_ph = PH_IDLE; m_waited = 0; m_jprev = 1'b0;
    cnt_reg = 0; cnt_conta = 0; cnt_ativo = 0;
  endtask

  initial begin
    @(negedge clock);
    check_eq("reset_state", {3'b000, dut_vec}, {3'b000, exp_out(PH_IDLE)});
    reset = 1'b1;

    // reset while in comparacao
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("in_cmp", {12'h000, db_estado}, 16'h0005);
    do_reset();

    // four correct positions
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int p = 0; p < 4; p++) begin
      cycle(1'b0, 1'b0, 1'b1, p == 3);
      cycle(1'b0, 1'b1, 1'b1, p == 3);
      for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b1, p == 3);
    end
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("win_reg_pulses", 16'(cnt_reg), 16'd4);
    check_eq("win_conta_pulses", 16'(cnt_conta), 16'd3);
    check_eq("win_acertou", {15'h0, acertou}, 16'h0001);

    // wrong play on second position, then restart
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int p = 0; p < 2; p++) begin
      cycle(1'b0, 1'b1, p == 0, 1'b0);
      for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, p == 0, 1'b0);
    end
    check_eq("err_conta_pulses", 16'(cnt_conta), 16'd1);
    check_eq("err_errou", {15'h0, errou}, 16'h0001);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("restart_prep", {12'h000, db_estado}, 16'h0001);

    // no press: full window then timeout
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 13; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("to_window_len", 16'(cnt_ativo), 16'(TO));
    check_eq("to_flag", {15'h0, timeout}, 16'h0001);

    // press on the last window cycle, then a fresh full window
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < TO - 1; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("late_press_reg", {15'h0, registraR}, 16'h0001);
    cnt_ativo = 0;
    for (int k = 0; k < 15; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("second_window_len", 16'(cnt_ativo), 16'(TO));

    // button held from inicial, press during registra/comparacao ignored
    do_reset();
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("held_no_reg", 16'(cnt_reg), 16'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("held_one_reg", 16'(cnt_reg), 16'd1);

    // randomized play: busy button, then sparse button to reach timeouts
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      cycle($urandom_range(0, 7) == 0,
            (n < 800) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
